// File: rtl/perspective_divide.sv
// Perspective-correct texture coordinate recovery: w = 1/(1/w), then u = (u/w)*w and v = (v/w)*w.
// Three-stage valid/ready pipeline with bubble collapsing; screen position and tag ride alongside.

module reciprocal #(
    parameter logic [31:0] NUMERATOR = 32'h1
) (
    input  logic [31:0] divisor_i,
    output logic [31:0] recip_o
);
    // Q16.16 divided by Q16.16 needs the numerator pre-scaled by 2^32 to land back in Q16.16.
    localparam logic [63:0] DIVIDEND = {NUMERATOR, 32'h0};

    logic [32:0] rem;
    logic [63:0] quot;

    always_comb begin
        rem  = '0;
        quot = '0;
        for (int i = 63; i >= 0; i--) begin
            rem = {rem[31:0], DIVIDEND[i]};
            if (rem >= {1'b0, divisor_i}) begin
                rem     = rem - {1'b0, divisor_i};
                quot[i] = 1'b1;
            end
        end
        // Out-of-range and zero divisors override the divider; large quotients saturate.
        if (divisor_i[31:30] != 2'b00) begin
            recip_o = '0;
        end else if (divisor_i == '0) begin
            recip_o = NUMERATOR << 16;
        end else if (quot[63:32] != '0) begin
            recip_o = '1;
        end else begin
            recip_o = quot[31:0];
        end
    end
endmodule

module perspective_divide #(
    parameter int          TAG_WIDTH = 8,
    parameter logic [31:0] NUMERATOR = 32'h1
) (
    input  logic                 clk,
    input  logic                 reset_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          inv_w_i,
    input  logic [31:0]          u_w_i,
    input  logic [31:0]          v_w_i,
    input  logic [15:0]          x_i,
    input  logic [15:0]          y_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [31:0]          u_o,
    output logic [31:0]          v_o,
    output logic [31:0]          w_o,
    output logic [15:0]          x_o,
    output logic [15:0]          y_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 range_err_o,
    output logic                 busy_o
);
    logic                 s1Valid_q, s2Valid_q, s3Valid_q;
    logic                 s1Valid_d, s2Valid_d, s3Valid_d;
    logic                 load1, load2, load3;

    logic [31:0]          s1InvW_q, s1Uw_q, s1Vw_q;
    logic [15:0]          s1X_q, s1Y_q;
    logic [TAG_WIDTH-1:0] s1Tag_q;

    logic [31:0]          s2W_q, s2Uw_q, s2Vw_q;
    logic [15:0]          s2X_q, s2Y_q;
    logic [TAG_WIDTH-1:0] s2Tag_q;
    logic                 s2Err_q;

    logic [31:0]          s3U_q, s3V_q, s3W_q;
    logic [15:0]          s3X_q, s3Y_q;
    logic [TAG_WIDTH-1:0] s3Tag_q;
    logic                 s3Err_q;

    logic [31:0]          recipW;
    logic signed [63:0]   uProd, vProd;

    reciprocal #(.NUMERATOR(NUMERATOR)) uRecip (
        .divisor_i (s1InvW_q),
        .recip_o   (recipW)
    );

    // A stage may advance whenever it is empty or its successor advances.
    assign load3   = !s3Valid_q || ready_i;
    assign load2   = !s2Valid_q || load3;
    assign load1   = !s1Valid_q || load2;
    assign ready_o = load1;

    always_comb begin
        s1Valid_d = load1 ? valid_i   : s1Valid_q;
        s2Valid_d = load2 ? s1Valid_q : s2Valid_q;
        s3Valid_d = load3 ? s2Valid_q : s3Valid_q;
        uProd = {{32{s2Uw_q[31]}}, s2Uw_q} * {{32{s2W_q[31]}}, s2W_q};
        vProd = {{32{s2Vw_q[31]}}, s2Vw_q} * {{32{s2W_q[31]}}, s2W_q};
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            s3Valid_q <= 1'b0;
            s1InvW_q  <= '0;
            s1Uw_q    <= '0;
            s1Vw_q    <= '0;
            s1X_q     <= '0;
            s1Y_q     <= '0;
            s1Tag_q   <= '0;
            s2W_q     <= '0;
            s2Uw_q    <= '0;
            s2Vw_q    <= '0;
            s2X_q     <= '0;
            s2Y_q     <= '0;
            s2Tag_q   <= '0;
            s2Err_q   <= 1'b0;
            s3U_q     <= '0;
            s3V_q     <= '0;
            s3W_q     <= '0;
            s3X_q     <= '0;
            s3Y_q     <= '0;
            s3Tag_q   <= '0;
            s3Err_q   <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s2Valid_q <= s2Valid_d;
            s3Valid_q <= s3Valid_d;
            // Data only moves with a valid predecessor, so emptied stages keep stale but harmless data.
            if (load1 && valid_i) begin
                s1InvW_q <= inv_w_i;
                s1Uw_q   <= u_w_i;
                s1Vw_q   <= v_w_i;
                s1X_q    <= x_i;
                s1Y_q    <= y_i;
                s1Tag_q  <= tag_i;
            end
            if (load2 && s1Valid_q) begin
                s2W_q   <= recipW;
                s2Uw_q  <= s1Uw_q;
                s2Vw_q  <= s1Vw_q;
                s2X_q   <= s1X_q;
                s2Y_q   <= s1Y_q;
                s2Tag_q <= s1Tag_q;
                s2Err_q <= (s1InvW_q[31:30] != 2'b00);
            end
            if (load3 && s2Valid_q) begin
                s3U_q   <= uProd[47:16];
                s3V_q   <= vProd[47:16];
                s3W_q   <= s2W_q;
                s3X_q   <= s2X_q;
                s3Y_q   <= s2Y_q;
                s3Tag_q <= s2Tag_q;
                s3Err_q <= s2Err_q;
            end
        end
    end

    assign valid_o     = s3Valid_q;
    assign u_o         = s3U_q;
    assign v_o         = s3V_q;
    assign w_o         = s3W_q;
    assign x_o         = s3X_q;
    assign y_o         = s3Y_q;
    assign tag_o       = s3Tag_q;
    assign range_err_o = s3Valid_q && s3Err_q;
    assign busy_o      = s1Valid_q || s2Valid_q || s3Valid_q;
endmodule

// File: tb/tb_perspective_divide.sv
// Self-checking bench for perspective_divide: directed steps plus random traffic against
// an arithmetic reference model and an in-order scoreboard.

module tb_perspective_divide;
    localparam int          TW  = 8;
    localparam logic [31:0] NUM = 32'h1;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          valid_i, ready_o, valid_o, ready_i, range_err_o, busy_o;
    logic [31:0]   inv_w_i, u_w_i, v_w_i, u_o, v_o, w_o;
    logic [15:0]   x_i, y_i, x_o, y_o;
    logic [TW-1:0] tag_i, tag_o;

    always #5 clk = ~clk;

    perspective_divide #(.TAG_WIDTH(TW), .NUMERATOR(NUM)) dut (
        .clk         (clk),
        .reset_ni    (reset_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .inv_w_i     (inv_w_i),
        .u_w_i       (u_w_i),
        .v_w_i       (v_w_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .tag_i       (tag_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .u_o         (u_o),
        .v_o         (v_o),
        .w_o         (w_o),
        .x_o         (x_o),
        .y_o         (y_o),
        .tag_o       (tag_o),
        .range_err_o (range_err_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic [31:0]   u, v, w;
        logic [15:0]   x, y;
        logic [TW-1:0] tag;
        logic          rerr;
        int            acc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0, failures = 0, cycle = 0;
    int          accepted = 0, delivered = 0, runLen = 0, maxRun = 0;
    bit          checkLat = 1'b0;
    logic [31:0] lastU, lastV, lastW;
    logic [TW-1:0] lastTag;
    logic        lastErr;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Reference: w = NUMERATOR / (1/w) in Q16.16, saturating, with the two special input ranges.
    function automatic logic [31:0] recipModel(input logic [31:0] d);
        logic [63:0] q;
        if (d >= 32'h4000_0000) return 32'h0;
        if (d == 32'h0) return NUM << 16;
        q = {NUM, 32'h0} / {32'h0, d};
        return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

    function automatic logic [31:0] rmul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        return 32'(p >>> 16);
    endfunction

    function automatic exp_t model(input logic [31:0] inv, input logic [31:0] uw, input logic [31:0] vw,
                                   input logic [15:0] x, input logic [15:0] y, input logic [TW-1:0] tag);
        exp_t e;
        e.w    = recipModel(inv);
        e.u    = rmul(uw, e.w);
        e.v    = rmul(vw, e.w);
        e.x    = x;
        e.y    = y;
        e.tag  = tag;
        e.rerr = (inv >= 32'h4000_0000);
        e.acc  = 0;
        return e;
    endfunction

    function automatic logic [31:0] randInvW();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h4000_0000 | $urandom;
            2:       return $urandom_range(1, 255);
            default: return $urandom_range(1, 32'h3FFF_FFFF);
        endcase
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] inv, input logic [31:0] uw,
                                 input logic [31:0] vw, input logic [TW-1:0] tag);
        valid_i = v;
        inv_w_i = inv;
        u_w_i   = uw;
        v_w_i   = vw;
        x_i     = 16'($urandom);
        y_i     = 16'($urandom);
        tag_i   = tag;
    endtask

    // One clock: sample and score at the falling edge, then return just after the rising edge.
    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (valid_o) begin
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
        end else begin
            runLen = 0;
        end
        if (valid_o) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(valid_o), 32'd0);
            end else begin
                e = sb[0];
                check("u_o", u_o, e.u);
                check("v_o", v_o, e.v);
                check("w_o", w_o, e.w);
                check("x_o", 32'(x_o), 32'(e.x));
                check("y_o", 32'(y_o), 32'(e.y));
                check("tag_o", 32'(tag_o), 32'(e.tag));
                check("range_err_o", 32'(range_err_o), 32'(e.rerr));
                if (ready_i) begin
                    if (checkLat) check("latency", 32'(cycle - e.acc), 32'd3);
                    lastU   = u_o;
                    lastV   = v_o;
                    lastW   = w_o;
                    lastTag = tag_o;
                    lastErr = range_err_o;
                    delivered++;
                    void'(sb.pop_front());
                end
            end
        end
        if (valid_i && ready_o) begin
            e     = model(inv_w_i, u_w_i, v_w_i, x_i, y_i, tag_i);
            e.acc = cycle;
            sb.push_back(e);
            accepted++;
        end
        cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        valid_i = 1'b0;
        while (sb.size() != 0 && n < limit) begin
            checkOutput();
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic sendOne(input logic [31:0] inv, input logic [31:0] uw, input logic [31:0] vw,
                           input logic [TW-1:0] tag);
        int a0, n;
        a0 = accepted;
        n  = 0;
        applyStimulus(1'b1, inv, uw, vw, tag);
        while (accepted == a0 && n < 20) begin
            checkOutput();
            n++;
        end
        if (accepted == a0) check("accept_timeout", 32'(accepted - a0), 32'd1);
        drain(20);
    endtask

    initial begin
        int          idx, a0, d0, guard;
        logic [31:0] bpInv[5];
        logic [31:0] bpU[5];
        logic [31:0] bpV[5];

        reset_ni = 1'b0;
        ready_i  = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_busy_o", 32'(busy_o), 32'd0);
        check("reset_ready_o", 32'(ready_o), 32'd1);
        check("reset_range_err_o", 32'(range_err_o), 32'd0);
        check("reset_u_o", u_o, 32'h0);
        check("reset_w_o", w_o, 32'h0);
        reset_ni = 1'b1;
        @(posedge clk);
        #1;

        checkLat = 1'b1;
        sendOne(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 8'h5A);
        check("single_w", lastW, 32'h0001_0000);
        check("single_u", lastU, 32'h0002_0000);
        check("single_v", lastV, 32'hFFFF_0000);
        check("single_tag", 32'(lastTag), 32'h5A);

        maxRun = 0;
        runLen = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, randInvW(), $urandom, $urandom, TW'(i));
            check("stream_ready_o", 32'(ready_o), 32'd1);
            checkOutput();
        end
        drain(20);
        check("stream_run", 32'(maxRun), 32'd16);
        checkLat = 1'b0;

        for (int i = 0; i < 5; i++) begin
            bpInv[i] = randInvW();
            bpU[i]   = $urandom;
            bpV[i]   = $urandom;
        end
        ready_i = 1'b0;
        idx = 0;
        a0  = accepted;
        d0  = delivered;
        repeat (6) begin
            applyStimulus(1'b1, bpInv[idx], bpU[idx], bpV[idx], TW'(8'h20 + idx));
            guard = accepted;
            checkOutput();
            if (accepted != guard) idx++;
        end
        check("bp_accepted", 32'(accepted - a0), 32'd3);
        check("bp_ready_o", 32'(ready_o), 32'd0);
        ready_i = 1'b1;
        guard   = 0;
        while (idx < 5 && guard < 20) begin
            applyStimulus(1'b1, bpInv[idx], bpU[idx], bpV[idx], TW'(8'h20 + idx));
            a0 = accepted;
            checkOutput();
            if (accepted != a0) idx++;
            guard++;
        end
        drain(20);
        check("bp_delivered", 32'(delivered - d0), 32'd5);

        a0    = accepted;
        d0    = delivered;
        guard = 0;
        while (accepted - a0 < 1000 && guard < 10000) begin
            ready_i = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), randInvW(), $urandom, $urandom, TW'($urandom));
            checkOutput();
            guard++;
        end
        if (accepted - a0 < 1000) check("random_timeout", 32'(accepted - a0), 32'd1000);
        ready_i = 1'b1;
        drain(50);
        check("random_delivered", 32'(delivered - d0), 32'(accepted - a0));
        check("random_queue_empty", 32'(sb.size()), 32'd0);

        sendOne(32'h4000_0000, 32'h0003_0000, 32'hFFFD_0000, 8'hA1);
        check("range_w", lastW, 32'h0);
        check("range_u", lastU, 32'h0);
        check("range_v", lastV, 32'h0);
        check("range_err", 32'(lastErr), 32'd1);
        sendOne(32'h0, 32'h0003_0000, 32'h0001_8000, 8'hA2);
        check("zero_w", lastW, 32'h0001_0000);
        check("zero_err", 32'(lastErr), 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, randInvW(), $urandom, $urandom, TW'(8'hC0 + i));
            checkOutput();
        end
        valid_i = 1'b0;
        check("pre_reset_valid_o", 32'(valid_o), 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        check("async_valid_o", 32'(valid_o), 32'd0);
        check("async_busy_o", 32'(busy_o), 32'd0);
        sb.delete();
        @(posedge clk);
        #3;
        reset_ni = 1'b1;
        repeat (6) begin
            checkOutput();
            check("post_reset_valid_o", 32'(valid_o), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/perspective_divide.md
Name: perspective_divide

Overview:
- Pipelined stage downstream of the rasterizer's attribute interpolator and upstream of the texture sampler.
- Accepts per-fragment interpolated 1/w, u/w and v/w in Q16.16 and recovers w with an internal `reciprocal` instance (NUMERATOR=1).
- Outputs perspective-correct u and v in Q16.16, using valid/ready handshakes on both sides.
- Carries fragment screen coordinates and a user tag alongside the data.

Parameters:
- TAG_WIDTH, 8, width of the opaque sideband tag carried with each fragment.
- NUMERATOR, 32'h1, numerator passed to the internal reciprocal instance.

Ports:
- clk  input  1  system clock.
- reset_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input fragment valid.
- ready_o  output  1  block can accept a fragment this cycle.
- inv_w_i  input  32  interpolated 1/w, Q16.16, unsigned.
- u_w_i  input  32  interpolated u/w, Q16.16, signed.
- v_w_i  input  32  interpolated v/w, Q16.16, signed.
- x_i  input  16  fragment x.
- y_i  input  16  fragment y.
- tag_i  input  TAG_WIDTH  opaque tag.
- valid_o  output  1  output fragment valid.
- ready_i  input  1  downstream accepts.
- u_o  output  32  perspective-correct u, Q16.16.
- v_o  output  32  perspective-correct v, Q16.16.
- w_o  output  32  recovered w, Q16.16.
- x_o  output  16  x passthrough.
- y_o  output  16  y passthrough.
- tag_o  output  TAG_WIDTH  tag passthrough.
- range_err_o  output  1  inv_w_i[31:30] nonzero; reciprocal returned 0.
- busy_o  output  1  any pipeline stage holds a valid fragment.

Behaviour:
- Reset is asynchronous on reset_ni low. All stage valid bits, valid_o, range_err_o and busy_o are forced to 0; data registers are cleared to 0. Release is synchronous to clk.
- Three register stages, S1 → S2 → S3; valid_o is S3 valid.
- S1 captures the inputs on valid_i & ready_o.
- S2 registers w = reciprocal(S1.inv_w), plus u_w, v_w, x, y, tag and range_err = (S1.inv_w[31:30] != 0).
- S3 registers:
  - u = rmul(S2.u_w, S2.w) and v = rmul(S2.v_w, S2.w).
  - rmul is a signed 32×32 → 64 product, arithmetic shift right 16, truncated to 32 bits; no saturation.
  - w, x, y, tag and range_err pass through.
- Latency: exactly 3 cycles from input accept to valid_o when ready_i is held high. Throughput is 1 fragment/cycle.
- Per-stage advance, bubble-collapsing:
  - S3 loads when S3 is empty or ready_i is high.
  - S2 loads when S2 is empty or S3 loads.
  - S1 loads when S1 is empty or S2 loads.
  - ready_o = S1 empty | S2 loads. This is combinational from ready_i; no combinational path from valid_i to ready_o.
- A stage that loads with an invalid predecessor becomes empty.
- Holding stages keep their data unchanged. Output fields remain stable while valid_o & !ready_i.
- If valid_i & ready_o & the output handshake fire in the same cycle, both transfers occur; no loss or duplication.
- inv_w_i = 0: the reciprocal yields NUMERATOR<<16. The output is that value, not an error; range_err stays 0.
- inv_w_i ≥ 32'h40000000: w = 0, u = v = 0, range_err_o = 1 for that fragment only.
- Fragments leave in acceptance order. Maximum occupancy is 3.
- busy_o = S1v | S2v | S3v, registered-equivalent (derived from stage valid flops only).
- Reset asserted mid-operation discards all in-flight fragments. After release, valid_o stays 0 until a new fragment has traversed 3 cycles.

Test Plan:
- Single fragment, ready_i=1: inv_w=32'h00010000, u_w=32'h00020000, v_w=32'hFFFF0000, tag=8'h5A → valid_o exactly 3 cycles after accept. w_o equals the golden `reciprocal` instance output; u_o = rmul(32'h00020000, w_o); v_o = rmul(32'hFFFF0000, w_o); tag_o=8'h5A.
- Back-to-back stream of 16 fragments, tags 0..15, ready_i=1 → valid_o high for 16 consecutive cycles. Tags emerge in order 0..15 and ready_o never drops.
- Backpressure: 5 fragments with ready_i=0 → exactly 3 accepted, then ready_o=0 and outputs are stable. Release ready_i → all 5 delivered in order with no duplicates.
- Random valid_i/ready_i at 50% over 1000 fragments → scoreboard against the golden model shows zero mismatches and zero drops.
- Range: inv_w=32'h40000000 → w_o=0, u_o=0, v_o=0, range_err_o=1. inv_w=0 → w_o=32'h00010000, range_err_o=0.
- Reset with 3 fragments in flight: assert reset_ni low mid-cycle → valid_o and busy_o drop immediately (asynchronously). After release, no stale fragment appears.
